// File: rtl/output_signature_compactor.sv
// Compacts wide core outputs into a MISR signature and a saturating sample count,
// with a serial dump port (signature MSB first, then count) driven from flops.
module output_signature_compactor #(
  parameter int               DATA_W = 128,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = '0,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              sig_out,
  output logic              sig_valid,
  output logic              sig_last,
  output logic              dump_done
);

  localparam int NSL  = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int TOT  = SIG_W + CNT_W;
  localparam int BC_W = $clog2(TOT + 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(TOT - 1);
  localparam logic [BC_W-1:0] PRE_LAST = BC_W'(TOT - 2);

  typedef enum logic [1:0] {ACCUM, SHIFT, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SIG_W-1:0]       r_sig;
  logic [CNT_W-1:0]       r_cnt;
  logic [TOT-1:0]         r_shift;
  logic [BC_W-1:0]        r_bitcnt;
  logic                   r_sig_out;
  logic                   r_sig_valid;
  logic                   r_sig_last;
  logic                   r_dump_done;
  logic [NSL*SIG_W-1:0]   w_pad;
  logic [SIG_W-1:0]       w_fold;
  logic [SIG_W-1:0]       w_misr;

  // Zero-pad the input to whole slices, then XOR all slices together.
  always_comb begin
    w_pad = '0;
    w_pad[DATA_W-1:0] = data_in;
    w_fold = '0;
    for (int i = 0; i < NSL; i++) begin
      w_fold = w_fold ^ w_pad[i*SIG_W +: SIG_W];
    end
  end

  assign w_misr = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_fold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sig <= SEED;
      r_cnt <= '0;
    end else if (clear) begin
      r_sig <= SEED;
      r_cnt <= '0;
    end else if (data_valid) begin
      r_sig <= w_misr;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (dump_req) w_state_nxt = SHIFT;
      SHIFT:   if (r_bitcnt == LAST_IDX) w_state_nxt = DONE;
      DONE:    w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // The snapshot takes the registered sig/count, never this cycle's MISR result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_sig_out   <= 1'b0;
      r_sig_valid <= 1'b0;
      r_sig_last  <= 1'b0;
      r_dump_done <= 1'b0;
    end else begin
      r_sig_valid <= (w_state_nxt == SHIFT);
      r_dump_done <= (w_state_nxt == DONE);
      r_sig_last  <= (r_state == SHIFT) && (r_bitcnt == PRE_LAST);
      r_sig_out   <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (dump_req) begin
            r_shift   <= {r_sig, r_cnt};
            r_sig_out <= r_sig[SIG_W-1];
            r_bitcnt  <= '0;
          end
        end
        SHIFT: begin
          if (r_bitcnt != LAST_IDX) begin
            r_shift   <= {r_shift[TOT-2:0], 1'b0};
            r_sig_out <= r_shift[TOT-2];
            r_bitcnt  <= r_bitcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dump_busy = (r_state != ACCUM);
  assign sig_out   = r_sig_out;
  assign sig_valid = r_sig_valid;
  assign sig_last  = r_sig_last;
  assign dump_done = r_dump_done;

endmodule

// File: tb/tb_output_signature_compactor.sv
// Randomized bench for output_signature_compactor against a behavioural MISR/count model.
module tb_output_signature_compactor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         data_valid = 1'b0;
  logic [127:0] data_in = '0;
  logic         dump_req = 1'b0;
  logic         dump_busy, sig_out, sig_valid, sig_last, dump_done;

  logic         s2_valid = 1'b0;
  logic         s2_clear = 1'b0;
  logic [7:0]   s2_data = '0;
  logic         s2_req = 1'b0;
  logic         s2_busy, s2_out, s2_svalid, s2_last, s2_done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_sig;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  output_signature_compactor dut (
    .clk(clk), .reset(rst_n), .clear(clear), .data_valid(data_valid),
    .data_in(data_in), .dump_req(dump_req), .dump_busy(dump_busy),
    .sig_out(sig_out), .sig_valid(sig_valid), .sig_last(sig_last),
    .dump_done(dump_done)
  );

  output_signature_compactor #(
    .DATA_W(8), .SIG_W(4), .POLY(4'h3), .SEED(4'h0), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(rst_n), .clear(s2_clear), .data_valid(s2_valid),
    .data_in(s2_data), .dump_req(s2_req), .dump_busy(s2_busy),
    .sig_out(s2_out), .sig_valid(s2_svalid), .sig_last(s2_last),
    .dump_done(s2_done)
  );

  // Signature update as polynomial arithmetic: multiply by x modulo POLY, add the folded word.
  function automatic logic [31:0] model_misr(input logic [31:0] s, input logic [127:0] d);
    logic [31:0] f;
    logic [32:0] prod;
    f = d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
    prod = {s, 1'b0};
    if (prod[32]) prod = prod ^ {1'b1, 32'h04C11DB7};
    return prod[31:0] ^ f;
  endfunction

  task automatic step(input logic v, input logic [127:0] d, input logic clr, input logic req);
    data_valid = v;
    data_in    = d;
    clear      = clr;
    dump_req   = req;
    @(negedge clk);
    if (clr) begin
      m_sig = '0;
      m_cnt = '0;
    end else if (v) begin
      m_sig = model_misr(m_sig, d);
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    data_valid = 1'b0; clear = 1'b0; dump_req = 1'b0; data_in = '0;
    s2_valid = 1'b0; s2_req = 1'b0; s2_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_sig = '0;
    m_cnt = '0;
  endtask

  task automatic do_dump(input logic fv, input logic [127:0] fd, input bit req_during,
                         input bit accum_during, output logic [47:0] snap,
                         output logic [47:0] bits, output int nbits,
                         output int last_at, output int done_at);
    logic v, c;
    snap = {m_sig, m_cnt};
    bits = '0; nbits = 0; last_at = -1; done_at = -1;
    step(fv, fd, 1'b0, 1'b1);
    for (int k = 1; k <= 70 && done_at < 0; k++) begin
      if (sig_valid) begin
        bits = {bits[46:0], sig_out};
        nbits++;
      end
      if (sig_last) last_at = k;
      if (dump_done) done_at = k;
      v = accum_during ? 1'($urandom_range(0, 1)) : 1'b0;
      c = accum_during ? ($urandom_range(0, 7) == 0) : 1'b0;
      step(v, {$urandom, $urandom, $urandom, $urandom}, c, req_during);
    end
    dump_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({dump_busy, sig_out, sig_valid, sig_last, dump_done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {dump_busy, sig_out, sig_valid, sig_last, dump_done});
    end
    do_reset();
    n_vec++;
    if ({s2_busy, s2_out, s2_svalid, s2_last, s2_done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs_small: got %b expected 00000",
               {s2_busy, s2_out, s2_svalid, s2_last, s2_done});
    end
  endtask

  task automatic test_dump_after_reset();
    logic [47:0] snap, bits;
    int nb, la, da;
    do_reset();
    do_dump(1'b0, '0, 1'b0, 1'b0, snap, bits, nb, la, da);
    n_vec++;
    if (bits !== 48'h0) begin n_err++; $display("FAIL t1_bits: got %h expected 0", bits); end
    n_vec++;
    if (nb !== 48) begin n_err++; $display("FAIL t1_nbits: got %0d expected 48", nb); end
    n_vec++;
    if (la !== 48) begin n_err++; $display("FAIL t1_last_pos: got %0d expected 48", la); end
    n_vec++;
    if (da !== 49) begin n_err++; $display("FAIL t1_done_pos: got %0d expected 49", da); end
  endtask

  task automatic test_directed();
    logic [47:0] snap, bits;
    int nb, la, da;
    do_reset();
    step(1'b1, 128'h1, 1'b0, 1'b0);
    step(1'b1, 128'h0, 1'b0, 1'b0);
    do_dump(1'b0, '0, 1'b0, 1'b0, snap, bits, nb, la, da);
    n_vec++;
    if (bits !== {32'h00000002, 16'd2}) begin
      n_err++; $display("FAIL t2_dump: got %h expected %h", bits, {32'h00000002, 16'd2});
    end
    do_reset();
    step(1'b1, {32'hA, 64'h0, 32'h5}, 1'b0, 1'b0);
    do_dump(1'b0, '0, 1'b0, 1'b0, snap, bits, nb, la, da);
    n_vec++;
    if (bits !== {32'h0000000F, 16'd1}) begin
      n_err++; $display("FAIL t3_fold: got %h expected %h", bits, {32'h0000000F, 16'd1});
    end
    do_reset();
    step(1'b1, 128'h80000000, 1'b0, 1'b0);
    step(1'b1, 128'h0, 1'b0, 1'b0);
    do_dump(1'b0, '0, 1'b0, 1'b0, snap, bits, nb, la, da);
    n_vec++;
    if (bits !== {32'h04C11DB7, 16'd2}) begin
      n_err++; $display("FAIL t4_poly: got %h expected %h", bits, {32'h04C11DB7, 16'd2});
    end
  endtask

  task automatic test_clear_and_ignored_req();
    logic [47:0] snap, bits;
    int nb, la, da, extra;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    do_dump(1'b0, '0, 1'b1, 1'b0, snap, bits, nb, la, da);
    n_vec++;
    if (bits !== 48'h0) begin n_err++; $display("FAIL t5_clear_wins: got %h expected 0", bits); end
    n_vec++;
    if (nb !== 48 || da !== 49) begin
      n_err++; $display("FAIL t5_one_dump: got bits=%0d done@%0d expected 48/49", nb, da);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (sig_valid || dump_busy) extra++;
      step(1'b0, '0, 1'b0, 1'b0);
    end
    n_vec++;
    if (extra !== 0) begin n_err++; $display("FAIL t5_no_second_dump: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_snapshot_timing();
    logic [47:0] snap, bits;
    int nb, la, da;
    do_reset();
    step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    do_dump(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, snap, bits, nb, la, da);
    n_vec++;
    if (bits[15:0] !== 16'd2) begin n_err++; $display("FAIL t6_count_pre_update: got %0d expected 2", bits[15:0]); end
    n_vec++;
    if (bits !== snap) begin n_err++; $display("FAIL t6_snapshot: got %h expected %h", bits, snap); end
  endtask

  task automatic test_random_back_to_back();
    logic [47:0] snap, bits;
    int nb, la, da, len;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(5, 60);
      for (int i = 0; i < len; i++)
        step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 15) == 0, 1'b0);
      do_dump(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
              it[0], 1'b1, snap, bits, nb, la, da);
      n_vec++;
      if (bits !== snap || nb !== 48 || la !== 48 || da !== 49) begin
        n_err++;
        $display("FAIL random_dump_%0d: got %h n=%0d last@%0d done@%0d expected %h n=48 last@48 done@49",
                 it, bits, nb, la, da, snap);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    logic [47:0] snap, bits;
    int nb, la, da;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({dump_busy, sig_out, sig_valid, sig_last, dump_done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_dump: got %b expected 00000",
               {dump_busy, sig_out, sig_valid, sig_last, dump_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_sig = '0;
    m_cnt = '0;
    do_dump(1'b0, '0, 1'b0, 1'b0, snap, bits, nb, la, da);
    n_vec++;
    if (bits !== 48'h0 || nb !== 48 || da !== 49) begin
      n_err++; $display("FAIL fresh_dump_after_reset: got %h n=%0d done@%0d expected 0 n=48 done@49", bits, nb, da);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] s;
    logic [5:0] bits;
    int nb;
    bit done_seen;
    do_reset();
    s = '0;
    for (int i = 0; i < 5; i++) begin
      s2_valid = 1'b1;
      s2_data  = 8'($urandom);
      @(negedge clk);
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0) ^ s2_data[3:0] ^ s2_data[7:4];
    end
    s2_valid = 1'b0;
    s2_req   = 1'b1;
    @(negedge clk);
    s2_req = 1'b0;
    bits = '0; nb = 0; done_seen = 0;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      if (s2_svalid) begin bits = {bits[4:0], s2_out}; nb++; end
      if (s2_done) done_seen = 1;
      @(negedge clk);
    end
    n_vec++;
    if (bits[1:0] !== 2'b11) begin n_err++; $display("FAIL sat_count: got %b expected 11", bits[1:0]); end
    n_vec++;
    if (bits[5:2] !== s || nb !== 6 || !done_seen) begin
      n_err++; $display("FAIL sat_sig: got %h n=%0d done=%0d expected %h n=6 done=1", bits[5:2], nb, done_seen, s);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_sig = '0;
    m_cnt = '0;
    test_reset();
    test_dump_after_reset();
    test_directed();
    test_clear_and_ignored_req();
    test_snapshot_timing();
    test_random_back_to_back();
    test_reset_mid_dump();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
